// File: rtl/icache_if.sv
// Bundle of signals between the instruction cache, the fetch unit and the memory
// interface's instruction port. The cache uses the slave view and its environment uses the master view.
interface icache_if;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [31:0] if_inst;
    logic        inst_valid;
    logic [31:0] inst_addr;
    logic [31:0] inst_result;
    logic        inst_ready;

    modport slave (
        input  if_valid, if_pc, inst_result, inst_ready,
        output if_ready, if_inst, inst_valid, inst_addr
    );

    modport master (
        output if_valid, if_pc, inst_result, inst_ready,
        input  if_ready, if_inst, inst_valid, inst_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits return one cycle after acceptance.
// A miss issues one word read to memory, then fills the line. rob_clear aborts a pending miss.
module icache #(
    parameter int INDEX_BITS = 4
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     rob_clear,
    icache_if.slave  bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic {IDLE, MISS} state_t;

    state_t      state_q, state_d;
    logic        if_ready_q, if_ready_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        inst_valid_q, inst_valid_d;
    logic [29:0] miss_word_q, miss_word_d;
    logic        fill_en;

    logic             valid_q  [LINES];
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]      req_tag, fill_tag;
    logic                  lookup_hit;
    wire                   unused_pc_bits = &{1'b0, bus.if_pc[1:0]};

    assign req_idx    = bus.if_pc[INDEX_BITS+1:2];
    assign req_tag    = bus.if_pc[31:INDEX_BITS+2];
    assign fill_idx   = miss_word_q[INDEX_BITS-1:0];
    assign fill_tag   = miss_word_q[29:INDEX_BITS];
    assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    // Holding the if_ready guard keeps a still-asserted request from being accepted twice.
    always_comb begin
        state_d      = state_q;
        if_ready_d   = if_ready_q;
        if_inst_d    = if_inst_q;
        inst_valid_d = inst_valid_q;
        miss_word_d  = miss_word_q;
        fill_en      = 1'b0;
        if (rdy_in) begin
            if_ready_d = 1'b0;
            if (rob_clear) begin
                state_d      = IDLE;
                inst_valid_d = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.if_valid && !if_ready_q) begin
                            if (lookup_hit) begin
                                if_ready_d = 1'b1;
                                if_inst_d  = data_mem[req_idx];
                            end else begin
                                state_d      = MISS;
                                inst_valid_d = 1'b1;
                                miss_word_d  = bus.if_pc[31:2];
                            end
                        end
                    end
                    MISS: begin
                        if (bus.inst_ready) begin
                            fill_en      = 1'b1;
                            if_ready_d   = 1'b1;
                            if_inst_d    = bus.inst_result;
                            inst_valid_d = 1'b0;
                            state_d      = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            if_ready_q   <= 1'b0;
            if_inst_q    <= 32'h0;
            inst_valid_q <= 1'b0;
            miss_word_q  <= 30'h0;
        end else begin
            state_q      <= state_d;
            if_ready_q   <= if_ready_d;
            if_inst_q    <= if_inst_d;
            inst_valid_q <= inst_valid_d;
            miss_word_q  <= miss_word_d;
        end
    end

    // Only the valid bits need reset. Tag and data are qualified by them.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    valid_q[gi] <= 1'b0;
                end else if (fill_en && (fill_idx == INDEX_BITS'(gi))) begin
                    valid_q[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= bus.inst_result;
        end
    end

    assign bus.if_ready   = if_ready_q;
    assign bus.if_inst    = if_inst_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_addr  = {miss_word_q, 2'b00};
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a table of fetch transactions plus hand-written flush,
// stall, idle-completion and asynchronous-reset sequences.
module tb_icache;
    logic clk_in;
    logic rst_in;
    logic rdy_in;
    logic rob_clear;

    icache_if bus();

    icache #(.INDEX_BITS(4)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .rob_clear (rob_clear),
        .bus       (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        miss;
        logic [31:0] word;
        int          lat;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one fetch from a negedge and respond as memory when it misses.
    task automatic do_fetch(input logic [31:0] pc, input logic miss, input logic [31:0] word,
                            input int lat, input logic [31:0] exp_inst);
        bus.if_valid = 1'b1;
        bus.if_pc    = pc;
        @(negedge clk_in);
        if (miss) begin
            check("miss_req_valid", {31'h0, bus.inst_valid}, 32'h1);
            check("miss_req_addr", bus.inst_addr, {pc[31:2], 2'b00});
            for (int c = 1; c < lat; c++) begin
                @(negedge clk_in);
                check("miss_hold_valid", {31'h0, bus.inst_valid}, 32'h1);
                check("miss_hold_addr", bus.inst_addr, {pc[31:2], 2'b00});
                check("miss_no_early_ready", {31'h0, bus.if_ready}, 32'h0);
            end
            bus.inst_ready  = 1'b1;
            bus.inst_result = word;
            @(negedge clk_in);
            bus.inst_ready = 1'b0;
        end else begin
            check("hit_no_mem_req", {31'h0, bus.inst_valid}, 32'h0);
        end
        check("resp_ready", {31'h0, bus.if_ready}, 32'h1);
        check("resp_inst", bus.if_inst, exp_inst);
        check("resp_mem_idle", {31'h0, bus.inst_valid}, 32'h0);
        $display("fetch pc=%h %s inst=%h", pc, miss ? "miss" : "hit ", bus.if_inst);
        bus.if_valid = 1'b0;
        @(negedge clk_in);
        check("ready_pulse_ends", {31'h0, bus.if_ready}, 32'h0);
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        rob_clear = 1'b0;
        bus.if_valid = 1'b0;
        bus.if_pc = 32'h0;
        bus.inst_result = 32'h0;
        bus.inst_ready = 1'b0;

        vecs[0]  = '{32'h0000_0000, 1'b1, 32'h0000_0013, 4, 32'h0000_0013};
        vecs[1]  = '{32'h0000_0000, 1'b0, 32'h0,         0, 32'h0000_0013};
        vecs[2]  = '{32'h0000_0040, 1'b1, 32'h0010_0093, 2, 32'h0010_0093};
        vecs[3]  = '{32'h0000_0040, 1'b0, 32'h0,         0, 32'h0010_0093};
        vecs[4]  = '{32'h0000_0000, 1'b1, 32'h0000_0013, 1, 32'h0000_0013};
        vecs[5]  = '{32'h0000_0003, 1'b0, 32'h0,         0, 32'h0000_0013};
        vecs[6]  = '{32'h0000_0024, 1'b1, 32'hABCD_0001, 1, 32'hABCD_0001};
        vecs[7]  = '{32'h0000_0026, 1'b0, 32'h0,         0, 32'hABCD_0001};
        vecs[8]  = '{32'hFFFF_FFFC, 1'b1, 32'h1234_5678, 2, 32'h1234_5678};
        vecs[9]  = '{32'hFFFF_FFFC, 1'b0, 32'h0,         0, 32'h1234_5678};
        vecs[10] = '{32'h0000_007C, 1'b1, 32'h0000_0055, 1, 32'h0000_0055};
        vecs[11] = '{32'hFFFF_FFFC, 1'b1, 32'h1234_5678, 3, 32'h1234_5678};

        @(negedge clk_in);
        @(negedge clk_in);
        check("rst_if_ready", {31'h0, bus.if_ready}, 32'h0);
        check("rst_if_inst", bus.if_inst, 32'h0);
        check("rst_inst_valid", {31'h0, bus.inst_valid}, 32'h0);
        check("rst_inst_addr", bus.inst_addr, 32'h0);
        rst_in = 1'b0;
        @(negedge clk_in);

        for (int i = 0; i < 12; i++) begin
            do_fetch(vecs[i].pc, vecs[i].miss, vecs[i].word, vecs[i].lat, vecs[i].exp_inst);
        end

        // Flush coinciding with memory completion: no fill, no response.
        bus.if_valid = 1'b1;
        bus.if_pc = 32'h0000_0008;
        @(negedge clk_in);
        check("flush_miss_valid", {31'h0, bus.inst_valid}, 32'h1);
        check("flush_miss_addr", bus.inst_addr, 32'h0000_0008);
        bus.inst_ready = 1'b1;
        bus.inst_result = 32'hDEAD_BEEF;
        rob_clear = 1'b1;
        bus.if_valid = 1'b0;
        @(negedge clk_in);
        bus.inst_ready = 1'b0;
        rob_clear = 1'b0;
        check("flush_no_ready", {31'h0, bus.if_ready}, 32'h0);
        check("flush_drop_valid", {31'h0, bus.inst_valid}, 32'h0);
        $display("flush pc=00000008 during completion");
        @(negedge clk_in);
        do_fetch(32'h0000_0008, 1'b1, 32'h1111_1111, 2, 32'h1111_1111);

        // Completion pulse while idle must be ignored.
        bus.inst_ready = 1'b1;
        bus.inst_result = 32'h7777_7777;
        @(negedge clk_in);
        bus.inst_ready = 1'b0;
        check("idle_ready_ignored", {31'h0, bus.if_ready}, 32'h0);
        $display("stray inst_ready while idle");
        do_fetch(32'h0000_0008, 1'b0, 32'h0, 0, 32'h1111_1111);

        // Stall during a hit response: outputs freeze, then the pulse ends one cycle after release.
        bus.if_valid = 1'b1;
        bus.if_pc = 32'h0000_0000;
        @(negedge clk_in);
        check("stall_hit_ready", {31'h0, bus.if_ready}, 32'h1);
        rdy_in = 1'b0;
        bus.if_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            check("stall_ready_frozen", {31'h0, bus.if_ready}, 32'h1);
            check("stall_inst_frozen", bus.if_inst, 32'h0000_0013);
            check("stall_no_mem", {31'h0, bus.inst_valid}, 32'h0);
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        check("stall_release_clears", {31'h0, bus.if_ready}, 32'h0);
        $display("stall 3 cycles during hit of pc=00000000");

        // Stall during a miss: the request stays put and a completion pulse is ignored.
        bus.if_valid = 1'b1;
        bus.if_pc = 32'h0000_0080;
        @(negedge clk_in);
        rdy_in = 1'b0;
        bus.inst_ready = 1'b1;
        bus.inst_result = 32'h2222_2222;
        @(negedge clk_in);
        bus.inst_ready = 1'b0;
        check("stall_miss_valid", {31'h0, bus.inst_valid}, 32'h1);
        check("stall_miss_no_fill", {31'h0, bus.if_ready}, 32'h0);
        rdy_in = 1'b1;
        $display("stall during miss of pc=00000080");

        // Asynchronous reset between clock edges while a miss is outstanding.
        check("areset_pre_valid", {31'h0, bus.inst_valid}, 32'h1);
        bus.if_valid = 1'b0;
        #2;
        rst_in = 1'b1;
        #1;
        check("areset_inst_valid", {31'h0, bus.inst_valid}, 32'h0);
        check("areset_inst_addr", bus.inst_addr, 32'h0);
        check("areset_if_ready", {31'h0, bus.if_ready}, 32'h0);
        $display("async reset during miss");
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        do_fetch(32'h0000_0000, 1'b1, 32'h0000_0013, 1, 32'h0000_0013);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the instruction fetch unit and the memory interface's instruction port (inst_valid / inst_addr / inst_result / inst_ready).
- Serves hits from local storage with 1-cycle latency.
- On a miss, issues a single word read to the memory interface, fills the line and forwards the word to fetch.
- rob_clear aborts an outstanding miss, matching the memory interface, which also drops its in-flight access on rob_clear.

Parameters:
INDEX_BITS, 4, log2 of line count (default 16 lines × 32-bit word).

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-high
rdy_in  input  1  global ready; block holds all state when low
rob_clear  input  1  pipeline flush; aborts outstanding miss
if_valid  input  1  fetch request valid, held until if_ready
if_pc  input  32  fetch address; bits [1:0] ignored
if_ready  output  1  one-cycle response pulse
if_inst  output  32  instruction word, valid while if_ready=1
inst_valid  output  1  read request to memory interface
inst_addr  output  32  word address to memory interface ({pc[31:2],2'b00})
inst_result  input  32  word from memory interface
inst_ready  input  1  memory interface completion pulse

Behaviour:
- Address split:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[31:INDEX_BITS+2], width 30-INDEX_BITS
- Storage per line: valid bit, tag, 32-bit data.
- Reset (async, rst_in=1), applied immediately:
  - all valid bits=0; state=IDLE
  - if_ready=0, if_inst=0, inst_valid=0, inst_addr=0
  - tag/data arrays need no reset.
- States: IDLE, MISS. All outputs are registered.
- rdy_in=0: no state, array or output register changes. rob_clear is also ignored while rdy_in=0.
- Acceptance: a request is accepted on a clock edge with rdy_in=1, state=IDLE, if_valid=1, if_ready=0, rob_clear=0. The if_ready=0 guard prevents a held request from being accepted twice, so peak throughput is 1 hit per 2 cycles.
- Hit (valid[index] && tag match) at acceptance:
  - next cycle if_ready=1, if_inst=data[index]; state stays IDLE
  - no memory request.
- Miss at acceptance:
  - state<=MISS; latch pc
  - next cycle inst_valid=1, inst_addr={pc[31:2],2'b00}.
- MISS:
  - inst_valid and inst_addr are held constant until inst_ready.
  - On the edge where inst_ready=1:
    - write valid=1, tag, data=inst_result into the latched index; this replaces any prior line
    - if_ready<=1, if_inst<=inst_result
    - inst_valid<=0; state<=IDLE.
- if_ready is high exactly one cycle per accepted request. It is cleared the cycle after assertion.
- rob_clear=1 (rdy_in=1):
  - state<=IDLE, inst_valid<=0, if_ready<=0
  - no fill even if inst_ready is simultaneously 1
  - no acceptance that cycle
  - valid bits are preserved (no invalidation).
- inst_ready while state=IDLE is ignored.
- Fetch must not change if_pc while if_valid=1 and if_ready=0. Behaviour is undefined otherwise.
- No self-modifying-code coherence: data stores do not update the cache.

Test Plan:
- Cold miss:
  - Stimulus: after reset, if_valid=1, if_pc=0x00000000.
  - Required: next cycle inst_valid=1, inst_addr=0x0. Drive inst_ready=1, inst_result=0x00000013 four cycles later. Next cycle if_ready=1, if_inst=0x00000013, inst_valid=0.
- Hit:
  - Stimulus: refetch 0x0.
  - Required: if_ready=1, if_inst=0x13 one cycle after acceptance; inst_valid stays 0 throughout.
- Conflict eviction (INDEX_BITS=4):
  - Stimulus: fetch 0x40 (index 0, new tag).
  - Required: miss with inst_addr=0x40. Fill 0x00100093 → if_inst=0x00100093. A following fetch of 0x0 misses again.
- Flush mid-miss:
  - Stimulus: fetch 0x8 misses; assert rob_clear in the same cycle as inst_ready=1 with 0xDEADBEEF.
  - Required: if_ready stays 0, inst_valid drops next cycle. A later fetch of 0x8 misses, i.e. no fill occurred.
- Stall:
  - Stimulus: during a hit response, hold rdy_in=0 for 3 cycles.
  - Required: if_ready, if_inst and state are frozen. On rdy_in=1, if_ready clears after one further cycle.
- Async reset mid-miss:
  - Stimulus: assert rst_in between clock edges while in MISS.
  - Required: inst_valid=0 immediately. After release, fetch of 0x0 misses (valid bits cleared).
